// File: rtl/register_bank.sv
// 32x32 general-purpose register file: two combinational read ports, one write port,
// asynchronous active-low clear. Define ZERO_REG_EN to hardwire register 0 to zero.
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] dataReadA,
    output logic [DATA_WIDTH-1:0] dataReadB,
    input  logic [ADDR_WIDTH-1:0] readRegA,
    input  logic [ADDR_WIDTH-1:0] readRegB,
    input  logic [ADDR_WIDTH-1:0] writeReg,
    input  logic                  readWrite,
    input  logic [DATA_WIDTH-1:0] writeData
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regFile_r [DEPTH];
    logic                  writeEn_s;

    // Qualify the write enable; the zero register silently drops its writes
    always_comb begin
        writeEn_s = readWrite;
`ifdef ZERO_REG_EN
        if (writeReg == {ADDR_WIDTH{1'b0}}) begin
            writeEn_s = 1'b0;
        end else begin
            writeEn_s = readWrite;
        end
`endif
    end

    // Register storage: asynchronous clear of the whole file, single write per edge
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regFile_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (writeEn_s) begin
            regFile_r[writeReg] <= writeData;
        end
    end

    // Read port A: no bypass, so a same-cycle write shows only after the edge
    always_comb begin
        dataReadA = regFile_r[readRegA];
`ifdef ZERO_REG_EN
        if (readRegA == {ADDR_WIDTH{1'b0}}) begin
            dataReadA = {DATA_WIDTH{1'b0}};
        end else begin
            dataReadA = regFile_r[readRegA];
        end
`endif
    end

    // Read port B: independent of port A and of the write enable
    always_comb begin
        dataReadB = regFile_r[readRegB];
`ifdef ZERO_REG_EN
        if (readRegB == {ADDR_WIDTH{1'b0}}) begin
            dataReadB = {DATA_WIDTH{1'b0}};
        end else begin
            dataReadB = regFile_r[readRegB];
        end
`endif
    end

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank: reset, writes, dual reads,
// no-bypass timing, mid-cycle clear and register 0 behaviour.
module tb_register_bank;

    logic        clock;
    logic        clear;
    logic [31:0] dataReadA;
    logic [31:0] dataReadB;
    logic [4:0]  readRegA;
    logic [4:0]  readRegB;
    logic [4:0]  writeReg;
    logic        readWrite;
    logic [31:0] writeData;

    int nAssert = 0;
    int nFail   = 0;

`ifdef ZERO_REG_EN
    localparam logic [31:0] REG0_EXPECT = 32'h0000_0000;
`else
    localparam logic [31:0] REG0_EXPECT = 32'h0000_0005;
`endif

    register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock     (clock),
        .clear     (clear),
        .dataReadA (dataReadA),
        .dataReadB (dataReadB),
        .readRegA  (readRegA),
        .readRegB  (readRegB),
        .writeReg  (writeReg),
        .readWrite (readWrite),
        .writeData (writeData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAssert++;
        assert (observed === expected) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive a write at the falling edge, let the next rising edge capture it
    task automatic doWrite(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clock);
        writeReg  = addr;
        writeData = data;
        readWrite = 1'b1;
        @(posedge clock);
        #1;
        readWrite = 1'b0;
    endtask

    // Release clear at a falling edge and leave a full idle cycle before any write
    task automatic releaseClear();
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        clear     = 1'b0;
        readWrite = 1'b0;
        writeReg  = 5'd0;
        writeData = 32'h0;
        readRegA  = 5'd4;
        readRegB  = 5'd7;
        #3;
        check("reset_a", dataReadA, 32'h0);
        check("reset_b", dataReadB, 32'h0);

        // Write attempted while clear is low must be ignored
        doWrite(5'd4, 32'hFFFF_FFFF);
        check("write_in_reset", dataReadA, 32'h0);

        releaseClear();

        // Basic write to reg 20
        readRegA = 5'd20;
        #1;
        check("basic_before", dataReadA, 32'h0);
        doWrite(5'd20, 32'd22);
        check("basic_after", dataReadA, 32'd22);

        // Write disabled: several edges with readWrite low
        @(negedge clock);
        writeReg  = 5'd20;
        writeData = 32'd99;
        readWrite = 1'b0;
        readRegB  = 5'd20;
        repeat (3) @(posedge clock);
        #1;
        check("disabled_a", dataReadA, 32'd22);
        check("disabled_b", dataReadB, 32'd22);

        // Dual-port read
        doWrite(5'd4, 32'h11);
        doWrite(5'd7, 32'h22);
        readRegA = 5'd4;
        readRegB = 5'd7;
        #1;
        check("dual_a", dataReadA, 32'h11);
        check("dual_b", dataReadB, 32'h22);
        readRegA = 5'd7;
        #1;
        check("same_spec_a", dataReadA, 32'h22);
        check("same_spec_b", dataReadB, 32'h22);

        // Top address
        doWrite(5'd31, 32'hDEAD_BEEF);
        readRegA = 5'd31;
        #1;
        check("reg31", dataReadA, 32'hDEAD_BEEF);

        // Same-register read/write: no bypass
        doWrite(5'd5, 32'h1234);
        readRegA = 5'd5;
        @(negedge clock);
        writeReg  = 5'd5;
        writeData = 32'hABCD;
        readWrite = 1'b1;
        #1;
        check("rw_old", dataReadA, 32'h1234);
        @(posedge clock);
        #1;
        readWrite = 1'b0;
        check("rw_new", dataReadA, 32'hABCD);

        // Clear mid-cycle takes effect without a clock edge
        #1;
        clear = 1'b0;
        #1;
        check("midclear_a", dataReadA, 32'h0);
        check("midclear_b", dataReadB, 32'h0);
        releaseClear();

        // Pending write lost when clear falls before its edge
        @(negedge clock);
        writeReg  = 5'd9;
        writeData = 32'h77;
        readWrite = 1'b1;
        readRegA  = 5'd9;
        #2;
        clear = 1'b0;
        @(posedge clock);
        #1;
        readWrite = 1'b0;
        check("lost_write", dataReadA, 32'h0);
        releaseClear();

        // Reset pulse clears previously written all-ones values
        doWrite(5'd4, 32'hFFFF_FFFF);
        doWrite(5'd7, 32'hFFFF_FFFF);
        readRegA = 5'd4;
        readRegB = 5'd7;
        #1;
        check("ones_a", dataReadA, 32'hFFFF_FFFF);
        check("ones_b", dataReadB, 32'hFFFF_FFFF);
        @(negedge clock);
        #2;
        clear = 1'b0;
        #1;
        check("pulse_a", dataReadA, 32'h0);
        check("pulse_b", dataReadB, 32'h0);
        releaseClear();

        // Register 0
        doWrite(5'd0, 32'h5);
        readRegA = 5'd0;
        readRegB = 5'd0;
        #1;
        check("reg0_a", dataReadA, REG0_EXPECT);
        check("reg0_b", dataReadB, REG0_EXPECT);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
